pwm_sdm_dac: RTL and testbench
==============================

Name: pwm_sdm_dac

Overview:
Multi-channel, width-parametrised audio DAC modulator, successor to the single-channel 8-bit PWM/first-order sigma-delta block.
- Accepts unsigned PCM samples through a valid/ready handshake into a per-frame double buffer.
- Drives one 1-bit modulated output per channel, in a runtime-selected mode: off, PWM, or first-order SDM.
- Sits between the tile input pins (or an upstream sample source) and the audio output pins; the external RC filter reconstructs the analogue signal.

Parameters:
WIDTH, 8, sample width in bits; PWM period and frame length are 2^WIDTH clocks.
CHANNELS, 2, number of independent output channels; all channels share one frame counter.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low all state holds and dac_out is forced to 0
mode  input  2  00 off, 01 PWM, 10 SDM1, 11 SDM2 (see Optional Feature)
sample_in  input  CHANNELS*WIDTH  packed samples, channel 0 in the LSBs
sample_valid  input  1  sample_in is valid this cycle
sample_ready  output  1  shadow buffer empty; a sample can be accepted
dac_out  output  CHANNELS  registered modulated bit per channel
frame_start  output  1  one-cycle pulse in the cycle after the frame counter wraps to 0
underrun  output  1  sticky: a frame boundary occurred with the shadow buffer empty

Behaviour:
- Reset (async assert, sync release) clears all state:
  - cnt=0; shadow, active and all accumulators = 0; shadow_full=0; mode_q=00.
  - Outputs: sample_ready=1, dac_out=0, frame_start=0, underrun=0.
- While ena=0, nothing advances (counter, buffers, accumulators); dac_out=0; sample_ready reflects shadow state but no transfer occurs.
- Frame counter: cnt is WIDTH bits and increments each enabled clock, wrapping 2^WIDTH-1 -> 0. The boundary cycle is the cycle with cnt==2^WIDTH-1.
- Handshake:
  - Transfer happens when sample_valid & sample_ready & ena; shadow <= sample_in and shadow_full <= 1.
  - sample_ready = !shadow_full, combinational from the register.
  - Data is held only in the shadow register; no skid.
- Boundary cycle:
  - If shadow_full: active <= shadow and shadow_full <= 0.
  - Otherwise active holds its previous value and underrun <= 1.
  - mode_q <= mode in the same cycle. If mode differs from mode_q, all accumulators clear to 0.
  - If a transfer and a boundary hit the same cycle with the shadow already full, the transfer cannot occur because ready=0. If the shadow was empty, the incoming sample lands in the shadow and is used at the next boundary.
- Modes, per channel c. Output is registered, so one clock of latency from cnt/acc to dac_out:
  - 00 off: dac_out[c]=0.
  - 01 PWM: dac_out[c] <= (active[c] > cnt). Value 0 gives a constant 0. Value 2^WIDTH-1 gives 1 for 2^WIDTH-1 of every 2^WIDTH clocks.
  - 10 SDM1: acc[c] is WIDTH+1 bits. acc[c] <= acc[c][WIDTH-1:0] + active[c]; dac_out[c] <= carry out of that sum (the new acc[c][WIDTH]). Long-run density of ones = active/2^WIDTH.
  - 11: see Optional Feature.
- mode only takes effect at frame boundaries (via mode_q); a change mid-frame is not visible until the next wrap.
- frame_start is a registered pulse, high for exactly one cycle when cnt becomes 0.

Optional Feature:
Macro PWM_SDM_DAC_SDM2_EN.
- Defined: mode 11 is a second-order sigma-delta modulator.
  - x = active - 2^(WIDTH-1), signed.
  - fb = y ? +2^(WIDTH-1) : -2^(WIDTH-1), where y is the channel's previous output bit.
  - i1 <= sat(i1 + x - fb); i2 <= sat(i2 + i1_new - fb).
  - i1 and i2 are signed WIDTH+4 bits and saturate at their min/max.
  - dac_out <= (i2_new >= 0).
- Undefined: mode 11 behaves identically to mode 10 and no i1/i2 registers are built.

Test Plan:
- Reset mid-frame: assert rst_n=0 asynchronously at cnt=100 with dac_out=1 -> dac_out, frame_start and underrun go 0 immediately; sample_ready=1.
- PWM, WIDTH=8: load ch0=64, ch1=255 before a boundary, mode=01 -> in the following frame ch0 is high for exactly 64 clocks and ch1 for 255; frame_start pulses every 256 clocks.
- SDM1: ch0=128 -> after the first frame, dac_out[0] alternates 1,0 (128 ones per 256 clocks). ch0=1 -> exactly one 1 per 256 clocks.
- Handshake and underrun:
  - Hold sample_valid=1 -> exactly one transfer per frame, and sample_ready drops the cycle after each transfer.
  - Stop supplying samples -> at the next boundary underrun=1 (stays 1) and active keeps its last value.
- Mode change mid-frame: switch 01 -> 10 at cnt=50 -> PWM continues until the wrap, then SDM starts from acc=0.
- With PWM_SDM_DAC_SDM2_EN, mode=11, ch0=128 -> ones density 50% +/-1 over 1024 clocks with no saturation. Without the macro -> output bit-identical to mode 10.

Source files
------------

// File: rtl/pwm_sdm_dac.sv
// rtl/pwm_sdm_dac.sv - multi-channel PWM / sigma-delta audio DAC modulator (option macro PWM_SDM_DAC_SDM2_EN: second-order SDM in mode 11)
module pwm_sdm_dac #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic [CHANNELS-1:0]       dac_out,
  output logic                      frame_start,
  output logic                      underrun
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0]          cnt;
  logic [CHANNELS*WIDTH-1:0] shadow;
  logic [CHANNELS*WIDTH-1:0] active;
  logic                      shadow_full;
  logic                      underrun_q;
  logic                      frame_start_q;
  logic [1:0]                mode_q;
  logic [CHANNELS-1:0]       dac_q;
  logic                      boundary;
  logic                      transfer;
  logic                      acc_clear;

  assign boundary     = ena && (cnt == CNT_MAX);
  assign transfer     = ena && sample_valid && !shadow_full;
  assign acc_clear    = boundary && (mode != mode_q);
  assign sample_ready = !shadow_full;
  assign dac_out      = ena ? dac_q : '0;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

`ifdef PWM_SDM_DAC_SDM2_EN
  localparam int IW = WIDTH + 4;

  // Clamp a two-bit-wider intermediate back into the integrator range
  function automatic logic signed [IW-1:0] sat(input logic signed [IW+1:0] v);
    if ((v[IW+1:IW-1] == 3'b000) || (v[IW+1:IW-1] == 3'b111))
      return $signed(v[IW-1:0]);
    else if (v[IW+1])
      return $signed({1'b1, {(IW-1){1'b0}}});
    else
      return $signed({1'b0, {(IW-1){1'b1}}});
  endfunction
`endif

  // Frame counter; frame_start marks the first cycle of each new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= boundary;
      if (ena) cnt <= cnt + 1'b1;
    end
  end

  // Shadow/active double buffer, frame-aligned mode latch and sticky underrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      active      <= '0;
      shadow_full <= 1'b0;
      underrun_q  <= 1'b0;
      mode_q      <= 2'b00;
    end else begin
      if (transfer) begin
        shadow      <= sample_in;
        shadow_full <= 1'b1;
      end
      if (boundary) begin
        mode_q <= mode;
        if (shadow_full) begin
          active      <= shadow;
          shadow_full <= 1'b0;
        end else begin
          underrun_q <= 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sdm1_sum;
    logic             dac_bit;
    logic             sdm1_sel;

    assign a        = active[c*WIDTH +: WIDTH];
    // The carry out of the residue sum is the first-order SDM output bit
    assign sdm1_sum = {1'b0, acc} + {1'b0, a};
    assign dac_q[c] = dac_bit;

`ifdef PWM_SDM_DAC_SDM2_EN
    localparam logic signed [IW+1:0] HALF = (IW+2)'(2 ** (WIDTH - 1));

    logic signed [IW-1:0] i1, i2, i1_new, i2_new;
    logic signed [IW+1:0] x_ext, fb_ext, i1_sum, i2_sum;

    assign sdm1_sel = (mode_q == 2'b10);
    assign x_ext    = $signed({{(IW+2-WIDTH){1'b0}}, a}) - HALF;
    assign fb_ext   = dac_bit ? HALF : -HALF;
    assign i1_sum   = $signed({{2{i1[IW-1]}}, i1}) + x_ext - fb_ext;
    assign i1_new   = sat(i1_sum);
    assign i2_sum   = $signed({{2{i2[IW-1]}}, i2}) + $signed({{2{i1_new[IW-1]}}, i1_new}) - fb_ext;
    assign i2_new   = sat(i2_sum);

    // Second-order integrator chain, restarted from zero on a mode change
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        i1 <= '0;
        i2 <= '0;
      end else if (ena) begin
        if (acc_clear) begin
          i1 <= '0;
          i2 <= '0;
        end else if (mode_q == 2'b11) begin
          i1 <= i1_new;
          i2 <= i2_new;
        end
      end
    end
`else
    assign sdm1_sel = mode_q[1];
`endif

    // Output bit from the mode latched at the last boundary; SDM residue update
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc     <= '0;
        dac_bit <= 1'b0;
      end else if (ena) begin
        case (mode_q)
          2'b00:   dac_bit <= 1'b0;
          2'b01:   dac_bit <= (a > cnt);
`ifdef PWM_SDM_DAC_SDM2_EN
          2'b11:   dac_bit <= ~i2_new[IW-1];
`endif
          default: dac_bit <= sdm1_sum[WIDTH];
        endcase
        if (acc_clear)     acc <= '0;
        else if (sdm1_sel) acc <= sdm1_sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pwm_sdm_dac.sv
// tb/tb_pwm_sdm_dac.sv - self-checking bench for pwm_sdm_dac
module tb_pwm_sdm_dac;
  localparam int W = 8;
  localparam int C = 2;
  localparam int N = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [C*W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic [C-1:0] dac_out;
  logic         frame_start;
  logic         underrun;

  always #5 clk = ~clk;

  pwm_sdm_dac #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .dac_out(dac_out), .frame_start(frame_start), .underrun(underrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: integer frame position, sample buffers, and for SDM
  // the running sum of all samples applied (a one is emitted whenever that
  // sum crosses another multiple of 2^W).
  int       m_cnt;
  int       m_shadow [C];
  int       m_active [C];
  int       m_total [C];
  int       m_mode_q;
  logic     m_full;
  logic     m_fs;
  logic     m_und;
  logic [C-1:0] m_dac;
  logic [C-1:0] m_known;

  always @(posedge clk or negedge rst_n) begin : model
    logic bnd;
    logic old_full;
    int   old_t;
    if (!rst_n) begin
      m_cnt = 0; m_full = 0; m_fs = 0; m_und = 0; m_mode_q = 0;
      m_dac = '0; m_known = '1;
      for (int c = 0; c < C; c++) begin
        m_shadow[c] = 0; m_active[c] = 0; m_total[c] = 0;
      end
    end else if (ena) begin
      bnd = (m_cnt == N - 1);
      old_full = m_full;
      for (int c = 0; c < C; c++) begin
        m_known[c] = 1'b1;
        case (m_mode_q)
          0: m_dac[c] = 1'b0;
          1: m_dac[c] = (m_active[c] > m_cnt);
          default: begin
`ifdef PWM_SDM_DAC_SDM2_EN
            if (m_mode_q == 3) m_known[c] = 1'b0; else
`endif
            begin
              old_t = m_total[c];
              m_total[c] = m_total[c] + m_active[c];
              m_dac[c] = ((m_total[c] / N) != (old_t / N));
            end
          end
        endcase
      end
      m_fs = bnd;
      if (bnd) begin
        if (int'(mode) != m_mode_q)
          for (int c = 0; c < C; c++) m_total[c] = 0;
        if (old_full) begin
          for (int c = 0; c < C; c++) m_active[c] = m_shadow[c];
          m_full = 1'b0;
        end else begin
          m_und = 1'b1;
        end
        m_mode_q = int'(mode);
      end
      if (sample_valid && !old_full) begin
        for (int c = 0; c < C; c++) m_shadow[c] = int'(sample_in[c*W +: W]);
        m_full = 1'b1;
      end
      m_cnt = (m_cnt + 1) % N;
    end else begin
      m_fs = 1'b0;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [C-1:0] mask;
    mask = ena ? m_known : '1;
    check("dac_out", 32'(dac_out & mask), 32'((ena ? m_dac : '0) & mask));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("underrun", 32'(underrun), 32'(m_und));
    check("sample_ready", 32'(sample_ready), 32'(!m_full));
  end

  task automatic wait_frame(input int limit);
    int k;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (frame_start === 1'b1) break;
      k++;
      if (k >= limit) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_start_timeout: got none within %0d cycles expected a pulse", limit);
        break;
      end
    end
  endtask

  initial begin
    int ones0, ones1, fs_cnt;
    repeat (3) @(negedge clk);
    check("reset sample_ready", 32'(sample_ready), 32'd1);
    check("reset dac_out", 32'(dac_out), 32'd0);
    check("reset frame_start", 32'(frame_start), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    #1 rst_n = 1'b1; ena = 1'b1;

    // PWM: ch0=64, ch1=255, valid held continuously
    sample_in = {8'd255, 8'd64};
    sample_valid = 1'b1;
    mode = 2'b01;
    @(negedge clk);
    check("ready after transfer", 32'(sample_ready), 32'd0);
    wait_frame(300);
    check("ready at frame start", 32'(sample_ready), 32'd1);
    sample_in = {8'd1, 8'd128};
    ones0 = 0; ones1 = 0; fs_cnt = 0;
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      ones0 += int'(dac_out[0]);
      ones1 += int'(dac_out[1]);
      if (i < N) fs_cnt += int'(frame_start);
      if (i == 1) check("ready drops after transfer", 32'(sample_ready), 32'd0);
      if (i == 50) mode = 2'b10;
    end
    check("pwm ch0 ones", 32'(ones0), 32'd64);
    check("pwm ch1 ones", 32'(ones1), 32'd255);
    check("no early frame_start", 32'(fs_cnt), 32'd0);
    check("frame_start period", 32'(frame_start), 32'd1);

    // SDM1: ch0=128, ch1=1; stop supplying samples
    sample_valid = 1'b0;
    ones0 = 0; ones1 = 0;
    for (int j = 1; j <= N; j++) begin
      @(negedge clk);
      ones0 += int'(dac_out[0]);
      ones1 += int'(dac_out[1]);
      if (j == 1) check("sdm1 first bit", 32'(dac_out[0]), 32'd0);
      if (j == 2) check("sdm1 second bit", 32'(dac_out[0]), 32'd1);
      if (j == 255) check("underrun before boundary", 32'(underrun), 32'd0);
      if (j == 128) mode = 2'b11;
    end
    check("sdm1 ch0 ones", 32'(ones0), 32'd128);
    check("sdm1 ch1 ones", 32'(ones1), 32'd1);
    check("underrun set", 32'(underrun), 32'd1);

    // Mode 11 over four frames; active keeps its last value
    ones0 = 0; ones1 = 0;
    for (int k = 1; k <= 4 * N; k++) begin
      @(negedge clk);
      ones0 += int'(dac_out[0]);
      ones1 += int'(dac_out[1]);
    end
`ifdef PWM_SDM_DAC_SDM2_EN
    check("sdm2 ch0 density in range", 32'(ones0 >= 511 && ones0 <= 513), 32'd1);
`else
    check("mode11 ch0 ones", 32'(ones0), 32'd512);
    check("mode11 ch1 ones", 32'(ones1), 32'd4);
`endif
    check("underrun sticky", 32'(underrun), 32'd1);

    // Disabled: nothing advances and outputs are forced low
    #1 ena = 1'b0;
    repeat (10) @(negedge clk);
    check("ena low dac_out", 32'(dac_out), 32'd0);
    check("ena low frame_start", 32'(frame_start), 32'd0);
    repeat (10) @(negedge clk);
    #1 ena = 1'b1;

    // Full-scale PWM, then asynchronous reset mid-frame
    sample_in = {8'd255, 8'd255};
    sample_valid = 1'b1;
    mode = 2'b01;
    wait_frame(300);
    sample_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("pwm full scale at cnt 100", 32'(dac_out), 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst dac_out", 32'(dac_out), 32'd0);
    check("async rst frame_start", 32'(frame_start), 32'd0);
    check("async rst underrun", 32'(underrun), 32'd0);
    check("async rst sample_ready", 32'(sample_ready), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    mode = 2'b10;
    sample_in = {8'd0, 8'd200};
    sample_valid = 1'b1;
    repeat (400) @(negedge clk);
    sample_valid = 1'b0;
    repeat (300) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
